// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD read ports with write bypass,
// a pending-write scoreboard for decode hazards, and a post-reset clear sweep.
module regfile_mp #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready_o,
  input  logic                       w0_en_i,
  input  logic [ADDR_W-1:0]          w0_addr_i,
  input  logic [DATA_W-1:0]          w0_data_i,
  input  logic                       w1_en_i,
  input  logic [ADDR_W-1:0]          w1_addr_i,
  input  logic [DATA_W-1:0]          w1_data_i,
  input  logic [NUM_RD-1:0]          r_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]   r_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   r_data_o,
  output logic [NUM_RD-1:0]          r_busy_o,
  input  logic                       claim_en_i,
  input  logic [ADDR_W-1:0]          claim_addr_i
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZERO  = (ZERO_REG_EN != 0);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_clr_cnt, w_clr_cnt_nxt;
  logic [DATA_W-1:0]     r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pending, w_pending_nxt;
  logic                  w_run;
  logic                  w_w0_ok, w_w1_ok;

  assign w_run   = (r_state == S_RUN);
  assign ready_o = w_run;
  assign w_w0_ok = w0_en_i && !(ZERO && (w0_addr_i == '0));
  assign w_w1_ok = w1_en_i && !(ZERO && (w1_addr_i == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == ADDR_W'(DEPTH-1)) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Port 1 is written last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) begin
        r_regs[r_clr_cnt] <= '0;
      end else begin
        if (w_w0_ok) r_regs[w0_addr_i] <= w0_data_i;
        if (w_w1_ok) r_regs[w1_addr_i] <= w1_data_i;
      end
    end
  end

  // A claim outranks a same-cycle write, so the set is applied after the clear.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_run) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((w_w0_ok && w0_addr_i == ADDR_W'(i)) ||
            (w_w1_ok && w1_addr_i == ADDR_W'(i)))
          w_pending_nxt[i] = 1'b0;
        if (claim_en_i && claim_addr_i == ADDR_W'(i))
          w_pending_nxt[i] = 1'b1;
      end
    end
    if (ZERO) w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit0, hit1;
    r_data_o = '0;
    r_busy_o = '0;
    a        = '0;
    hit0     = 1'b0;
    hit1     = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a    = r_addr_i[k*ADDR_W +: ADDR_W];
      hit0 = w0_en_i && (w0_addr_i == a);
      hit1 = w1_en_i && (w1_addr_i == a);
      if (w_run && r_en_i[k]) begin
        if (ZERO && a == '0)
          r_data_o[k*DATA_W +: DATA_W] = '0;
        else if (hit1)
          r_data_o[k*DATA_W +: DATA_W] = w1_data_i;
        else if (hit0)
          r_data_o[k*DATA_W +: DATA_W] = w0_data_i;
        else
          r_data_o[k*DATA_W +: DATA_W] = r_regs[a];
        r_busy_o[k] = r_pending[a] & ~(hit0 | hit1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_o;
  logic        w0_en_i, w1_en_i;
  logic [2:0]  w0_addr_i, w1_addr_i;
  logic [15:0] w0_data_i, w1_data_i;
  logic [1:0]  r_en_i;
  logic [5:0]  r_addr_i;
  logic [31:0] r_data_o;
  logic [1:0]  r_busy_o;
  logic        claim_en_i;
  logic [2:0]  claim_addr_i;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG_EN(1)) dut (
    .clk(clk), .rst(rst), .ready_o(ready_o),
    .w0_en_i(w0_en_i), .w0_addr_i(w0_addr_i), .w0_data_i(w0_data_i),
    .w1_en_i(w1_en_i), .w1_addr_i(w1_addr_i), .w1_data_i(w1_data_i),
    .r_en_i(r_en_i), .r_addr_i(r_addr_i), .r_data_o(r_data_o), .r_busy_o(r_busy_o),
    .claim_en_i(claim_en_i), .claim_addr_i(claim_addr_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    w0_en_i = 0; w0_addr_i = '0; w0_data_i = '0;
    w1_en_i = 0; w1_addr_i = '0; w1_data_i = '0;
    claim_en_i = 0; claim_addr_i = '0;
  endtask

  task automatic set_rd(input logic [1:0] en, input logic [2:0] a0, input logic [2:0] a1);
    r_en_i = en;
    r_addr_i = {a1, a0};
  endtask

  // Counts negedges with ready_o low, starting at the current negedge.
  task automatic count_clear(input string name);
    int cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready_o) break;
      cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt !== 8 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: ready low for %0d cycles (ready=%b), expected 8 then 1", name, cnt, ready_o);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < 8; a++) begin
      set_rd(2'b11, 3'(a), 3'(7 - a));
      #1;
      n_tests++;
      if (r_data_o !== 32'h0) begin
        n_fail++;
        $display("FAIL %s: addr %0d got %h expected 00000000", name, a, r_data_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle();
    set_rd(2'b11, 3'd3, 3'd5);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (ready_o !== 1'b0 || r_data_o !== 32'h0 || r_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b data=%h busy=%b expected 0/00000000/00", ready_o, r_data_o, r_busy_o);
    end
    @(negedge clk);
    rst = 0;
    count_clear("clear_len");
    check_all_zero("clear_zero");
  endtask

  task automatic test_write_read();
    idle();
    w0_en_i = 1; w0_addr_i = 3'd3; w0_data_i = 16'hBEEF;
    set_rd(2'b11, 3'd3, 3'd3);
    #1;
    n_tests++;
    if (r_data_o !== 32'hBEEF_BEEF) begin
      n_fail++;
      $display("FAIL wr_bypass: got %h expected beefbeef", r_data_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (r_data_o[15:0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wr_array: got %h expected beef", r_data_o[15:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_dual_write();
    idle();
    w0_en_i = 1; w0_addr_i = 3'd5; w0_data_i = 16'h1111;
    w1_en_i = 1; w1_addr_i = 3'd5; w1_data_i = 16'h2222;
    set_rd(2'b10, 3'd0, 3'd5);
    #1;
    n_tests++;
    if (r_data_o[31:16] !== 16'h2222) begin
      n_fail++;
      $display("FAIL dual_bypass: got %h expected 2222", r_data_o[31:16]);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (r_data_o[31:16] !== 16'h2222) begin
      n_fail++;
      $display("FAIL dual_array: got %h expected 2222", r_data_o[31:16]);
    end
    @(negedge clk);
    w0_en_i = 1; w0_addr_i = 3'd6; w0_data_i = 16'h0606;
    w1_en_i = 1; w1_addr_i = 3'd7; w1_data_i = 16'h0707;
    set_rd(2'b11, 3'd6, 3'd7);
    #1;
    n_tests++;
    if (r_data_o !== 32'h0707_0606) begin
      n_fail++;
      $display("FAIL split_bypass: got %h expected 07070606", r_data_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (r_data_o !== 32'h0707_0606) begin
      n_fail++;
      $display("FAIL split_array: got %h expected 07070606", r_data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    idle();
    w0_en_i = 1; w0_addr_i = 3'd0; w0_data_i = 16'hFFFF;
    w1_en_i = 1; w1_addr_i = 3'd0; w1_data_i = 16'hEEEE;
    claim_en_i = 1; claim_addr_i = 3'd0;
    set_rd(2'b11, 3'd0, 3'd0);
    #1;
    n_tests++;
    if (r_data_o !== 32'h0 || r_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_same: data=%h busy=%b expected 00000000/00", r_data_o, r_busy_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (r_data_o !== 32'h0 || r_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_next: data=%h busy=%b expected 00000000/00", r_data_o, r_busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_scoreboard();
    idle();
    claim_en_i = 1; claim_addr_i = 3'd4;
    set_rd(2'b01, 3'd4, 3'd0);
    #1;
    n_tests++;
    if (r_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL claim_same: busy=%b expected 00", r_busy_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (r_busy_o !== 2'b01) begin
      n_fail++;
      $display("FAIL claim_next: busy=%b expected 01", r_busy_o);
    end
    @(negedge clk);
    w0_en_i = 1; w0_addr_i = 3'd4; w0_data_i = 16'h4444;
    claim_en_i = 1; claim_addr_i = 3'd4;
    #1;
    n_tests++;
    if (r_busy_o !== 2'b00 || r_data_o[15:0] !== 16'h4444) begin
      n_fail++;
      $display("FAIL wr_claim_same: busy=%b data=%h expected 00/4444", r_busy_o, r_data_o[15:0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (r_busy_o !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_claim_next: busy=%b expected 01", r_busy_o);
    end
    set_rd(2'b00, 3'd4, 3'd4);
    #1;
    n_tests++;
    if (r_busy_o !== 2'b00 || r_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_disabled: busy=%b data=%h expected 00/00000000", r_busy_o, r_data_o);
    end
    @(negedge clk);
    set_rd(2'b11, 3'd4, 3'd4);
    w1_en_i = 1; w1_addr_i = 3'd4; w1_data_i = 16'h4545;
    #1;
    n_tests++;
    if (r_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_clear_same: busy=%b expected 00", r_busy_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if (r_busy_o !== 2'b00 || r_data_o !== 32'h4545_4545) begin
      n_fail++;
      $display("FAIL wr_clear_next: busy=%b data=%h expected 00/45454545", r_busy_o, r_data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    idle();
    w0_en_i = 1; w0_addr_i = 3'd1; w0_data_i = 16'hAAAA;
    claim_en_i = 1; claim_addr_i = 3'd2;
    @(negedge clk);
    idle();
    set_rd(2'b11, 3'd2, 3'd1);
    #1;
    n_tests++;
    if (r_busy_o !== 2'b01 || r_data_o[31:16] !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b data1=%h expected 01/aaaa", r_busy_o, r_data_o[31:16]);
    end
    rst = 1;
    @(negedge clk);
    n_tests++;
    if (ready_o !== 1'b0 || r_busy_o !== 2'b00 || r_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b busy=%b data=%h expected 0/00/00000000", ready_o, r_busy_o, r_data_o);
    end
    rst = 0;
    count_clear("mid_clear_len");
    n_tests++;
    if (r_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_pending: busy=%b expected 00", r_busy_o);
    end
    check_all_zero("mid_clear_zero");
  endtask

  initial begin
    idle();
    r_en_i = '0;
    r_addr_i = '0;
    rst = 1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general register file for the THCO-MIPS pipeline: two write ports and NUM_RD read ports, with write-to-read bypass and a per-register pending-write scoreboard that feeds the decode-stage hazard logic. After reset, a clear sequencer zeroes every register one per cycle, then raises `ready_o`. It sits between ID (reads and claims) and WB plus a second writer (e.g. a MEM or special-register path).

## Interface
- DATA_W, 16: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: number of read ports, at least 1.
- ZERO_REG_EN, 1: if 1, register 0 always reads 0, is never written and is never pending.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ready_o  out  1  high once the clear sequence has finished.
- w0_en_i / w1_en_i  in  1  write enables, ports 0 and 1.
- w0_addr_i / w1_addr_i  in  ADDR_W  write addresses.
- w0_data_i / w1_data_i  in  DATA_W  write data.
- r_en_i  in  NUM_RD  per-port read enable; bit k is port k.
- r_addr_i  in  NUM_RD*ADDR_W  read addresses; slice k is port k.
- r_data_o  out  NUM_RD*DATA_W  read data, combinational.
- r_busy_o  out  NUM_RD  the addressed register has an outstanding claim and no same-cycle write is bypassing it.
- claim_en_i  in  1  mark a register as awaiting a write (issued by ID).
- claim_addr_i  in  ADDR_W  register being claimed.

## Operation
- The sequencer has two states, CLEAR and RUN. A cycle with rst high leads to CLEAR, with clr_cnt = 0, ready_o = 0 and all pending bits = 0.
- CLEAR:
  - Each cycle, writes 0 to regs[clr_cnt] and increments clr_cnt.
  - After the cycle that clears index DEPTH-1, moves to RUN.
  - Write ports and claims are ignored.
  - r_data_o = 0 and r_busy_o = 0.
- RUN, writes:
  - On a rising edge, each enabled port writes its address. Writes to address 0 are dropped when ZERO_REG_EN = 1.
  - If both ports target the same address, port 1 wins.
- RUN, reads (port k, combinational):
  - If r_en low, r_data = 0.
  - Else if address 0 and ZERO_REG_EN = 1, r_data = 0.
  - Else if w1 is enabled and matches, r_data = w1_data.
  - Else if w0 is enabled and matches, r_data = w0_data.
  - Else r_data = regs[addr].
- Scoreboard (RUN only):
  - On an edge, pending[claim_addr] is set to 1.
  - An enabled write to an address clears that address's pending bit.
  - If a claim and a write hit the same address in the same cycle, the claim wins and the bit stays 1.
  - pending[0] stays 0 when ZERO_REG_EN = 1.
- r_busy_o[k] = r_en[k] & pending[addr] & ~(a write this cycle to addr).
- A mid-operation rst discards all pending bits and restarts CLEAR from index 0. Register contents are overwritten by the new sweep.

## Timing
- Reset values: ready_o = 0, r_data_o = 0, r_busy_o = 0, all pending bits = 0.
- Read latency is 0 cycles. A write is visible the same cycle via bypass and from the array on the next cycle.
- Clear takes DEPTH cycles after rst deasserts (8 with ADDR_W = 3).
  - ready_o rises on the edge that ends the last clear cycle.
  - ready_o stays high until the next rst.
- A claim is visible on r_busy_o the cycle after claim_en_i.
- A write clears busy combinationally in its own cycle and through the pending bit from the next cycle on.
- There is no backpressure. Writes are always accepted in RUN.

## Test plan
- Reset, then clear: hold rst for 2 cycles, release. Required: ready_o = 0 for exactly 8 cycles, then 1. Reading any address afterwards returns 0x0000.
- Write then read: write regs[3] = 0xBEEF via w0. In the same cycle, read port 0 at address 3 returns 0xBEEF (bypass). The next cycle, with no write, it still returns 0xBEEF.
- Dual write conflict: w0 and w1 both write address 5, with 0x1111 and 0x2222. Required: bypass read = 0x2222, and the array holds 0x2222 afterwards.
- Zero register: write 0xFFFF to address 0 and claim address 0. Required: reads return 0 and busy stays 0.
- Scoreboard:
  - Claim address 4. The next cycle r_busy_o = 1.
  - Write address 4 plus a claim of address 4 in the same cycle: busy = 0 that cycle and busy = 1 the next cycle.
  - A write alone then clears busy.
- Mid-run reset: with registers holding data and address 2 pending, assert rst for 1 cycle. Required: ready_o = 0, busy = 0, 8 clear cycles, after which every register reads 0.
